// File: rtl/mio_bus_responder.sv
// Responder side of the CPU memory/IO handshake: decodes each accepted request
// to RAM, a peripheral register or unmapped space, performs the access and
// returns a single-cycle mio_ready pulse with read data and an error flag.
module mio_bus_responder #(
    parameter int unsigned RAM_AW  = 10,
    parameter int unsigned RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_mio,
    input  logic              mem_r,
    input  logic              mem_w,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              mio_ready,
    output logic [31:0]       rdata,
    output logic              bus_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    input  logic [15:0]       sw_in,
    output logic [31:0]       gpio_out,
    output logic [1:0]        state_out
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RAM_ACC  = 2'b01,
        RAM_WAIT = 2'b10,
        RESP     = 2'b11
    } state_t;

    localparam logic [31:0] GPIO_ADDR = 32'hE000_0000;
    localparam logic [31:0] SW_ADDR   = 32'hF000_0000;
    localparam logic [31:0] CNT_ADDR  = 32'hF000_0004;

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        wait_cnt;
    logic              lat_we;
    logic              err_q;
    logic [RAM_AW-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic [31:0]       rdata_q;
    logic [31:0]       gpio_q;
    logic [31:0]       cyc_cnt;

    logic [31:0]       word_addr;
    logic              sel_ram;
    logic              sel_gpio;
    logic              sel_sw;
    logic              sel_cnt;
    logic              req_valid;
    logic              req_err;
    logic              accept;
    logic              reg_write;
    logic              ram_rd_done;

    // Address decode and request classification from the live CPU inputs.
    always_comb begin
        word_addr   = addr & 32'hFFFF_FFFC;
        sel_ram     = (addr[31:28] == 4'h0);
        sel_gpio    = (word_addr == GPIO_ADDR);
        sel_sw      = (word_addr == SW_ADDR);
        sel_cnt     = (word_addr == CNT_ADDR);
        req_valid   = cpu_mio & (mem_r | mem_w);
        req_err     = (mem_r & mem_w)
                    | ~(sel_ram | sel_gpio | sel_sw | sel_cnt)
                    | (mem_w & sel_sw);
        accept      = (state == IDLE) & req_valid;
        reg_write   = accept & ~req_err & mem_w;
        ram_rd_done = (state == RAM_WAIT) & (wait_cnt == 3'd0);
    end

    // Next-state logic of the access sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (req_valid) state_nxt = (sel_ram && !req_err) ? RAM_ACC : RESP;
            RAM_ACC:  state_nxt = lat_we ? RESP : RAM_WAIT;
            RAM_WAIT: if (wait_cnt == 3'd0) state_nxt = RESP;
            RESP:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Latch the request at the accepting edge so later input changes are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            err_q     <= 1'b0;
        end else if (accept) begin
            lat_we    <= mem_w;
            lat_addr  <= addr[RAM_AW+1:2];
            lat_wdata <= wdata;
            err_q     <= req_err;
        end
    end

    // RAM read wait counter: loaded on the strobe cycle, counts down to the data cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                   wait_cnt <= '0;
        else if (state == RAM_ACC)                   wait_cnt <= 3'(RAM_LAT - 1);
        else if (state == RAM_WAIT && wait_cnt != 0) wait_cnt <= wait_cnt - 3'd1;
    end

    // Read data: register reads and errors resolve at acceptance, RAM reads at the data cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (accept) begin
            if (req_err)              rdata_q <= '0;
            else if (mem_r && sel_gpio) rdata_q <= gpio_q;
            else if (mem_r && sel_sw)   rdata_q <= {16'h0000, sw_in};
            else if (mem_r && sel_cnt)  rdata_q <= cyc_cnt;
        end else if (ram_rd_done) begin
            rdata_q <= ram_dout;
        end
    end

    // GPIO output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                     gpio_q <= '0;
        else if (reg_write && sel_gpio) gpio_q <= wdata;
    end

    // Free-running cycle counter; a CPU write wins over the increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                     cyc_cnt <= '0;
        else if (reg_write && sel_cnt) cyc_cnt <= wdata;
        else                           cyc_cnt <= cyc_cnt + 32'd1;
    end

    assign mio_ready = (state == RESP);
    assign bus_err   = (state == RESP) & err_q;
    assign ram_en    = (state == RAM_ACC);
    assign ram_we    = (state == RAM_ACC) & lat_we;
    assign ram_addr  = lat_addr;
    assign ram_din   = lat_wdata;
    assign rdata     = rdata_q;
    assign gpio_out  = gpio_q;
    assign state_out = state;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Directed bench for mio_bus_responder: one instance with RAM_LAT=1 and one
// with RAM_LAT=3, each with a behavioural RAM of matching read latency.
module tb_mio_bus_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_mio, mem_r, mem_w, use3;
    logic [31:0] addr, wdata;
    logic [15:0] sw_in;

    logic        cpu_mio_1, mio_ready_1, bus_err_1, ram_en_1, ram_we_1;
    logic [31:0] rdata_1, ram_din_1, ram_dout_1, gpio_out_1;
    logic [9:0]  ram_addr_1;
    logic [1:0]  state_out_1;

    logic        cpu_mio_3, mio_ready_3, bus_err_3, ram_en_3, ram_we_3;
    logic [31:0] rdata_3, ram_din_3, ram_dout_3, gpio_out_3;
    logic [9:0]  ram_addr_3;
    logic [1:0]  state_out_3;

    logic        rdy, berr;
    logic [31:0] rdat;

    logic [31:0] mem1 [0:1023];
    logic [31:0] mem3 [0:1023];
    logic [31:0] pipe1;
    logic [31:0] pipe3 [0:2];

    int edge_no = 0;
    int en_cnt1 = 0, en_cnt3 = 0, rdy_cnt3 = 0;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    assign cpu_mio_1 = cpu_mio & ~use3;
    assign cpu_mio_3 = cpu_mio & use3;
    assign rdy  = use3 ? mio_ready_3 : mio_ready_1;
    assign berr = use3 ? bus_err_3   : bus_err_1;
    assign rdat = use3 ? rdata_3     : rdata_1;

    mio_bus_responder #(.RAM_AW(10), .RAM_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .cpu_mio(cpu_mio_1), .mem_r(mem_r), .mem_w(mem_w),
        .addr(addr), .wdata(wdata), .mio_ready(mio_ready_1), .rdata(rdata_1),
        .bus_err(bus_err_1), .ram_en(ram_en_1), .ram_we(ram_we_1), .ram_addr(ram_addr_1),
        .ram_din(ram_din_1), .ram_dout(ram_dout_1), .sw_in(sw_in), .gpio_out(gpio_out_1),
        .state_out(state_out_1)
    );

    mio_bus_responder #(.RAM_AW(10), .RAM_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .cpu_mio(cpu_mio_3), .mem_r(mem_r), .mem_w(mem_w),
        .addr(addr), .wdata(wdata), .mio_ready(mio_ready_3), .rdata(rdata_3),
        .bus_err(bus_err_3), .ram_en(ram_en_3), .ram_we(ram_we_3), .ram_addr(ram_addr_3),
        .ram_din(ram_din_3), .ram_dout(ram_dout_3), .sw_in(sw_in), .gpio_out(gpio_out_3),
        .state_out(state_out_3)
    );

    // RAM models: data valid only in the cycle RAM_LAT after the strobe, junk otherwise.
    always @(posedge clk) begin
        if (ram_en_1 && ram_we_1) mem1[ram_addr_1] <= ram_din_1;
        pipe1 <= ram_en_1 ? mem1[ram_addr_1] : 32'hBAD0_0001;
        if (ram_en_3 && ram_we_3) mem3[ram_addr_3] <= ram_din_3;
        pipe3[0] <= ram_en_3 ? mem3[ram_addr_3] : 32'hBAD0_0003;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
        edge_no  <= edge_no + 1;
    end
    assign ram_dout_1 = pipe1;
    assign ram_dout_3 = pipe3[2];

    always @(negedge clk) begin
        if (ram_en_1)    en_cnt1++;
        if (ram_en_3)    en_cnt3++;
        if (mio_ready_3) rdy_cnt3++;
    end

    task automatic do_req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic er, output int acc);
        @(negedge clk);
        cpu_mio = 1'b1; mem_r = r; mem_w = w; addr = a; wdata = d;
        @(posedge clk);
        #1 acc = edge_no;
        @(negedge clk);
        cpu_mio = 1'b0; mem_r = 1'b0; mem_w = 1'b0;
        lat = 1;
        while (!rdy && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = rdat;
        er = berr;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if ({mio_ready_1, bus_err_1, ram_en_1, ram_we_1, state_out_1} !== 6'b0) begin failures++; $display("FAIL reset_ctl1: got %b expected 000000", {mio_ready_1, bus_err_1, ram_en_1, ram_we_1, state_out_1}); end
        checks++; if ({mio_ready_3, bus_err_3, ram_en_3, ram_we_3, state_out_3} !== 6'b0) begin failures++; $display("FAIL reset_ctl3: got %b expected 000000", {mio_ready_3, bus_err_3, ram_en_3, ram_we_3, state_out_3}); end
        checks++; if ({rdata_1, ram_din_1, gpio_out_1} !== 96'h0) begin failures++; $display("FAIL reset_data1: got %h expected 0", {rdata_1, ram_din_1, gpio_out_1}); end
        checks++; if (ram_addr_1 !== 10'd0) begin failures++; $display("FAIL reset_ram_addr: got %h expected 000", ram_addr_1); end
        reset = 1'b0;
    endtask

    task automatic test_ram();
        int lat, acc, e0; logic [31:0] rd; logic er;
        use3 = 1'b0;
        @(negedge clk);
        cpu_mio = 1'b1; mem_r = 1'b0; mem_w = 1'b1; addr = 32'h0000_0010; wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        cpu_mio = 1'b0; mem_w = 1'b0;
        checks++; if ({ram_en_1, ram_we_1, mio_ready_1} !== 3'b110) begin failures++; $display("FAIL ramw_strobe: got %b expected 110", {ram_en_1, ram_we_1, mio_ready_1}); end
        checks++; if (ram_addr_1 !== 10'd4) begin failures++; $display("FAIL ramw_addr: got %h expected 004", ram_addr_1); end
        checks++; if (ram_din_1 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ramw_din: got %h expected deadbeef", ram_din_1); end
        @(negedge clk);
        checks++; if ({mio_ready_1, bus_err_1, ram_en_1} !== 3'b100) begin failures++; $display("FAIL ramw_ready: got %b expected 100", {mio_ready_1, bus_err_1, ram_en_1}); end
        #2 e0 = en_cnt1;
        do_req(1'b1, 1'b0, 32'h0000_0010, 32'h0, lat, rd, er, acc);
        checks++; if (lat !== 3) begin failures++; $display("FAIL ramr_latency: got %0d expected 3", lat); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ramr_data: got %h expected deadbeef", rd); end
        #2;
        checks++; if (en_cnt1 - e0 !== 1) begin failures++; $display("FAIL ramr_en_count: got %0d expected 1", en_cnt1 - e0); end
    endtask

    task automatic test_gpio_sw();
        int lat, acc; logic [31:0] rd; logic er;
        use3 = 1'b0;
        do_req(1'b0, 1'b1, 32'hE000_0000, 32'h0000_00A5, lat, rd, er, acc);
        checks++; if (lat !== 1) begin failures++; $display("FAIL gpiow_latency: got %0d expected 1", lat); end
        checks++; if (gpio_out_1 !== 32'h0000_00A5) begin failures++; $display("FAIL gpiow_value: got %h expected 000000a5", gpio_out_1); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL gpiow_rdata_held: got %h expected deadbeef", rd); end
        sw_in = 16'h1234;
        do_req(1'b1, 1'b0, 32'hF000_0000, 32'h0, lat, rd, er, acc);
        checks++; if ({lat, rd, er} !== {32'd1, 32'h0000_1234, 1'b0}) begin failures++; $display("FAIL sw_read: got lat=%0d data=%h err=%b expected lat=1 data=00001234 err=0", lat, rd, er); end
        do_req(1'b1, 1'b0, 32'hE000_0002, 32'h0, lat, rd, er, acc);
        checks++; if ({rd, er} !== {32'h0000_00A5, 1'b0}) begin failures++; $display("FAIL gpio_read_lsb: got data=%h err=%b expected 000000a5 0", rd, er); end
    endtask

    task automatic test_counter();
        int lat, e1, e2; logic [31:0] rd, expv; logic er;
        use3 = 1'b0;
        do_req(1'b0, 1'b1, 32'hF000_0004, 32'hFFFF_FFFE, lat, rd, er, e1);
        repeat (2) @(negedge clk);
        do_req(1'b1, 1'b0, 32'hF000_0004, 32'h0, lat, rd, er, e2);
        expv = 32'hFFFF_FFFE + 32'(e2 - e1 - 1);
        checks++; if (rd !== expv) begin failures++; $display("FAIL counter_wrap: got %h expected %h", rd, expv); end
        checks++; if (rd !== 32'h0000_0001) begin failures++; $display("FAIL counter_value: got %h expected 00000001", rd); end
    endtask

    task automatic test_errors();
        int lat, acc, e0; logic [31:0] rd; logic er;
        use3 = 1'b0;
        #2 e0 = en_cnt1;
        do_req(1'b1, 1'b0, 32'h8000_0000, 32'h0, lat, rd, er, acc);
        checks++; if ({lat, er, rd} !== {32'd1, 1'b1, 32'h0}) begin failures++; $display("FAIL err_unmapped: got lat=%0d err=%b data=%h expected 1 1 0", lat, er, rd); end
        do_req(1'b1, 1'b0, 32'hF000_0000, 32'h0, lat, rd, er, acc);
        do_req(1'b0, 1'b1, 32'hF000_0000, 32'h1111_1111, lat, rd, er, acc);
        checks++; if ({lat, er, rd} !== {32'd1, 1'b1, 32'h0}) begin failures++; $display("FAIL err_sw_write: got lat=%0d err=%b data=%h expected 1 1 0", lat, er, rd); end
        do_req(1'b1, 1'b1, 32'h0000_0010, 32'h0, lat, rd, er, acc);
        checks++; if ({lat, er, rd} !== {32'd1, 1'b1, 32'h0}) begin failures++; $display("FAIL err_rw_both: got lat=%0d err=%b data=%h expected 1 1 0", lat, er, rd); end
        checks++; if (gpio_out_1 !== 32'h0000_00A5) begin failures++; $display("FAIL err_gpio_kept: got %h expected 000000a5", gpio_out_1); end
        #2;
        checks++; if (en_cnt1 - e0 !== 0) begin failures++; $display("FAIL err_no_ram_en: got %0d expected 0", en_cnt1 - e0); end
        do_req(1'b1, 1'b0, 32'h0000_0010, 32'h0, lat, rd, er, acc);
        checks++; if ({rd, er} !== {32'hDEAD_BEEF, 1'b0}) begin failures++; $display("FAIL err_ram_intact: got %h err=%b expected deadbeef 0", rd, er); end
    endtask

    task automatic test_back_to_back();
        int lat, acc, e0, r0; logic [31:0] rd; logic er; logic [3:0] pat;
        use3 = 1'b0;
        sw_in = 16'h00AB;
        @(negedge clk);
        cpu_mio = 1'b1; mem_r = 1'b1; mem_w = 1'b0; addr = 32'hF000_0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pat[i] = mio_ready_1;
            if (i == 2) begin cpu_mio = 1'b0; mem_r = 1'b0; end
        end
        checks++; if (pat !== 4'b0101) begin failures++; $display("FAIL held_reaccept: got %b expected 0101", pat); end
        checks++; if (rdata_1 !== 32'h0000_00AB) begin failures++; $display("FAIL held_rdata: got %h expected 000000ab", rdata_1); end

        use3 = 1'b1;
        do_req(1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, lat, rd, er, acc);
        checks++; if (lat !== 2) begin failures++; $display("FAIL lat3_write_latency: got %0d expected 2", lat); end
        #2 e0 = en_cnt3; r0 = rdy_cnt3;
        @(negedge clk);
        cpu_mio = 1'b1; mem_r = 1'b1; mem_w = 1'b0; addr = 32'h0000_0010; wdata = 32'h0;
        @(posedge clk);
        @(negedge clk);
        lat = 1;
        while (!mio_ready_3 && lat < 20) begin
            mem_r = 1'b0; mem_w = 1'b1; addr = 32'hE000_0000; wdata = 32'hFFFF_FFFF;
            @(negedge clk);
            lat++;
        end
        cpu_mio = 1'b0; mem_r = 1'b0; mem_w = 1'b0;
        checks++; if (lat !== 5) begin failures++; $display("FAIL lat3_read_latency: got %0d expected 5", lat); end
        checks++; if ({rdata_3, bus_err_3} !== {32'h1234_5678, 1'b0}) begin failures++; $display("FAIL lat3_read_data: got %h err=%b expected 12345678 0", rdata_3, bus_err_3); end
        repeat (3) @(negedge clk);
        checks++; if (gpio_out_3 !== 32'h0) begin failures++; $display("FAIL ignored_gpio: got %h expected 00000000", gpio_out_3); end
        #2;
        checks++; if ({en_cnt3 - e0, rdy_cnt3 - r0} !== {32'd1, 32'd1}) begin failures++; $display("FAIL ignored_counts: got en=%0d rdy=%0d expected 1 1", en_cnt3 - e0, rdy_cnt3 - r0); end
    endtask

    task automatic test_reset_mid();
        int e0, r0;
        use3 = 1'b1;
        @(negedge clk);
        cpu_mio = 1'b1; mem_r = 1'b1; mem_w = 1'b0; addr = 32'h0000_0010; wdata = 32'h5A5A_5A5A;
        @(posedge clk);
        @(negedge clk);
        cpu_mio = 1'b0; mem_r = 1'b0;
        @(negedge clk);
        checks++; if (state_out_3 !== 2'b10) begin failures++; $display("FAIL mid_state_wait: got %b expected 10", state_out_3); end
        reset = 1'b1;
        #1;
        checks++; if ({mio_ready_3, bus_err_3, ram_en_3, ram_we_3, state_out_3} !== 6'b0) begin failures++; $display("FAIL mid_reset_ctl: got %b expected 000000", {mio_ready_3, bus_err_3, ram_en_3, ram_we_3, state_out_3}); end
        checks++; if ({rdata_3, ram_din_3, gpio_out_1} !== 96'h0) begin failures++; $display("FAIL mid_reset_data: got %h expected 0", {rdata_3, ram_din_3, gpio_out_1}); end
        checks++; if (ram_addr_3 !== 10'd0) begin failures++; $display("FAIL mid_reset_addr: got %h expected 000", ram_addr_3); end
        @(negedge clk);
        reset = 1'b0;
        #2 e0 = en_cnt3; r0 = rdy_cnt3;
        repeat (5) @(negedge clk);
        #2;
        checks++; if ({en_cnt3 - e0, rdy_cnt3 - r0} !== {32'd0, 32'd0}) begin failures++; $display("FAIL mid_reset_quiet: got en=%0d rdy=%0d expected 0 0", en_cnt3 - e0, rdy_cnt3 - r0); end
    endtask

    initial begin
        reset = 1'b1; cpu_mio = 1'b0; mem_r = 1'b0; mem_w = 1'b0; use3 = 1'b0;
        addr = 32'h0; wdata = 32'h0; sw_in = 16'h0;
        repeat (2) @(negedge clk);
        test_reset();
        test_ram();
        test_gpio_sw();
        test_counter();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
